// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings, FSM state and stage-record type for the hazard unit
package core_pkg;

  // Widest register address a stage record can carry; narrower addresses are zero-extended.
  localparam int REC_AW = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              load;
    logic              store;
    logic [REC_AW-1:0] rd;
  } stage_rec_t;

  // A stage produces a value for src when it writes a real (non-x0) register equal to src.
  function automatic logic rec_match(input stage_rec_t r, input logic [REC_AW-1:0] src);
    return r.valid && r.reg_write && (r.rd != '0) && (r.rd == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_mux.sv
// rtl/hazard_fwd_mux.sv - forward select for one EX source operand
module hazard_fwd_mux
  import core_pkg::*;
(
  input  logic [REC_AW-1:0] src_i,
  input  stage_rec_t        mem_i,
  input  stage_rec_t        wb_i,
  output logic [1:0]        sel_o
);

  // Store flags and the WB load flag play no part in operand selection.
  logic unused_bits;
  assign unused_bits = ^{mem_i.store, wb_i.load, wb_i.store};

  // MEM wins over WB as the younger producer; a load in MEM has no data yet.
  always_comb begin
    sel_o = FWD_RF;
    if (rec_match(mem_i, src_i) && !mem_i.load) begin
      sel_o = FWD_MEM;
    end else if (rec_match(wb_i, src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard detection, forwarding and stall control; HAZARD_PERF_EN adds perf counters
module hazard_unit
  import core_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_load,
  input  logic              id_store,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  input  logic              mem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              hz_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  wait_cnt
);

  stage_rec_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_rec;
  logic [REC_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [REC_AW-1:0] id_rs1_w, id_rs2_w, id_rd_w;
  hz_state_t         state_q, state_d;
  logic              mem_wait, load_use;

  assign id_rs1_w = REC_AW'(id_rs1);
  assign id_rs2_w = REC_AW'(id_rs2);
  assign id_rd_w  = REC_AW'(id_rd);

  assign id_rec = '{valid: id_valid, reg_write: id_reg_write, load: id_load,
                    store: id_store, rd: id_rd_w};

  assign mem_wait = mem_q.valid && (mem_q.load || mem_q.store) && !mem_ready;
  assign load_use = id_valid && ex_q.valid && ex_q.load && (ex_q.rd != '0) &&
                    ((ex_q.rd == id_rs1_w) || (ex_q.rd == id_rs2_w));

  // Pipeline control: memory wait beats redirect, redirect beats load-use; silent in reset.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (ex_redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Shadow record advance: freeze EX/MEM during a memory wait, bubble EX on redirect or load-use.
  always_comb begin
    ex_d     = ex_q;
    ex_rs1_d = ex_rs1_q;
    ex_rs2_d = ex_rs2_q;
    mem_d    = mem_q;
    wb_d     = mem_q;
    if (mem_wait) begin
      wb_d = '0;
    end else begin
      mem_d = ex_q;
      if (ex_redirect || load_use) begin
        ex_d     = '0;
        ex_rs1_d = '0;
        ex_rs2_d = '0;
      end else begin
        ex_d     = id_rec;
        ex_rs1_d = id_rs1_w;
        ex_rs2_d = id_rs2_w;
      end
    end
  end

  // Shadow record registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
    end else begin
      ex_q     <= ex_d;
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
    end
  end

  // FSM next state: enter MEM_WAIT on a stalled access, leave on the first ready cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN:      if (mem_wait)  state_d = HZ_MEM_WAIT;
      HZ_MEM_WAIT: if (mem_ready) state_d = HZ_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HZ_RUN;
    else     state_q <= state_d;
  end

  assign hz_state = state_q;

  hazard_fwd_mux u_fwd_a (.src_i(ex_rs1_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(forward_a));
  hazard_fwd_mux u_fwd_b (.src_i(ex_rs2_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(forward_b));

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (stall_d && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_d && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
      if ((state_q == HZ_MEM_WAIT) && (wait_cnt_q != '1)) wait_cnt_q <= wait_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_reg_write, id_load, id_store;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_redirect, mem_ready;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_w;
  logic [1:0]  forward_a, forward_b;
  logic        hz_state;
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
  logic [10:0] ctrl;

  int n_pass = 0;
  int n_checks = 0;

  hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_load(id_load), .id_store(id_store),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .forward_a(forward_a), .forward_b(forward_b), .hz_state(hz_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, forward_a, forward_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic rw, input logic ld, input logic st,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_valid = v; id_reg_write = rw; id_load = ld; id_store = st;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      id_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_redirect = 1'b1;
    mem_ready = 1'b1;
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    next_cycle();
    next_cycle();
    check("reset_ctrl", 32'(ctrl), 32'h0);
    check("reset_state", 32'(hz_state), 32'h0);
    check("reset_cnt", stall_cnt | flush_cnt | wait_cnt, 32'h0);
    ex_redirect = 1'b0;
    rst = 1'b0;
    next_cycle();

    // ADD x5 in MEM, consumer rs1=x5 in EX
    id_set(1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5); next_cycle();
    id_set(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 5'd8); #1;
    check("alu_no_stall", 32'(stall_d), 32'h0);
    next_cycle();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #1;
    check("alu_fwd_a", 32'(forward_a), 32'h2);
    check("alu_fwd_b", 32'(forward_b), 32'h0);
    idle(3);

    // two writers of x5: the MEM one is younger and wins
    id_set(1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5); next_cycle();
    id_set(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd5); next_cycle();
    id_set(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd9); next_cycle();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #1;
    check("prio_fwd_a", 32'(forward_a), 32'h2);
    check("prio_fwd_b", 32'(forward_b), 32'h2);
    idle(3);

    // LW x7 in EX, ID rs2=x7: one stall cycle, then WB forward
    id_set(1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd7); next_cycle();
    id_set(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd7, 5'd9); #1;
    check("lu_stall", 32'({stall_f, stall_d, flush_e, stall_e, flush_d}), 32'h1C);
    next_cycle();
    check("lu_one_cycle", 32'({stall_f, stall_d, flush_e}), 32'h0);
    next_cycle();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #1;
    check("lu_fwd_b", 32'(forward_b), 32'h1);
    check("lu_fwd_a", 32'(forward_a), 32'h0);
    idle(3);

    // x0 writers never forward or stall
    id_set(1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0); next_cycle();
    id_set(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #1;
    check("x0_no_lu", 32'({stall_d, flush_e}), 32'h0);
    next_cycle();
    id_set(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4); next_cycle();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #1;
    check("x0_fwd", 32'({forward_a, forward_b}), 32'h0);
    check("x0_stall", 32'(stall_d), 32'h0);
    idle(3);

    // redirect together with load-use: redirect wins
    id_set(1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd7); next_cycle();
    id_set(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd7, 5'd9);
    ex_redirect = 1'b1; #1;
    check("redir_flush", 32'({flush_d, flush_e}), 32'h3);
    check("redir_stall", 32'({stall_f, stall_d}), 32'h0);
    next_cycle();
    ex_redirect = 1'b0;
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #1;
    check("redir_bubble", 32'({stall_d, forward_a, forward_b}), 32'h0);
    idle(3);

    // SW in MEM with three not-ready cycles; a redirect waits behind the memory stall
    id_set(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 5'd3, 5'd0); next_cycle();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); next_cycle();
    mem_ready = 1'b0;
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_stall", 32'({stall_f, stall_d, stall_e, stall_m, flush_w}), 32'h1F);
      check("mw_no_redir", 32'(flush_d), 32'h0);
      check("mw_state", 32'(hz_state), (i == 0) ? 32'h0 : 32'h1);
      next_cycle();
    end
    mem_ready = 1'b1; #1;
    check("mw_release", 32'(stall_m), 32'h0);
    check("mw_redir_late", 32'(flush_d), 32'h1);
    check("mw_state_last", 32'(hz_state), 32'h1);
    next_cycle();
    ex_redirect = 1'b0; #1;
    check("mw_run", 32'(hz_state), 32'h0);
`ifdef HAZARD_PERF_EN
    check("cnt_wait", wait_cnt, 32'd3);
    check("cnt_stall", stall_cnt, 32'd4);
    check("cnt_flush", flush_cnt, 32'd2);
`else
    check("cnt_tied", stall_cnt | flush_cnt | wait_cnt, 32'h0);
`endif
    idle(3);

    // reset in the middle of a memory wait
    id_set(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 5'd3, 5'd0); next_cycle();
    id_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); next_cycle();
    mem_ready = 1'b0; #1;
    check("rw_stall", 32'(stall_m), 32'h1);
    next_cycle();
    check("rw_state", 32'(hz_state), 32'h1);
    rst = 1'b1; #1;
    check("rw_async_ctrl", 32'(ctrl), 32'h0);
    check("rw_async_state", 32'(hz_state), 32'h0);
    next_cycle();
    check("rw_edge_ctrl", 32'(ctrl), 32'h0);
    check("rw_edge_state", 32'(hz_state), 32'h0);
    rst = 1'b0; #1;
    check("rw_post_stall", 32'({stall_f, stall_d, stall_e, stall_m, flush_w}), 32'h0);
    next_cycle();
    check("rw_post_state", 32'(hz_state), 32'h0);
    check("rw_post_cnt", stall_cnt | flush_cnt | wait_cnt, 32'h0);
    mem_ready = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
